// File: rtl/switch_mcu_regfile_mp_pkg.sv
// Shared definitions for the switch MCU core: default register-file
// geometry and the address-width helper.
package switch_mcu_pkg;

    localparam int SWM_DATA_W    = 32;
    localparam int SWM_RF_DEPTH  = 32;
    localparam int SWM_RF_NUM_RD = 2;

    function automatic int swm_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/switch_mcu_regfile_mp_if.sv
// Register-file bus between decode/writeback (master) and the register file (slave).
// Reads have no backpressure: in_ren[k] is a one-cycle request and out_rvalid[k] pulses once, one cycle later.
interface switch_mcu_regfile_mp_if
    import switch_mcu_pkg::*;
#(
    parameter int DATA_W = SWM_DATA_W,
    parameter int DEPTH  = SWM_RF_DEPTH,
    parameter int NUM_RD = SWM_RF_NUM_RD
);
    localparam int AW = swm_aw(DEPTH);

    logic                     in_wen;
    logic [AW-1:0]            in_waddr;
    logic [DATA_W-1:0]        in_wdata;
    logic [NUM_RD-1:0]        in_ren;
    logic [NUM_RD*AW-1:0]     in_raddr;
    logic [NUM_RD*DATA_W-1:0] out_rdata;
    logic [NUM_RD-1:0]        out_rvalid;
    logic [NUM_RD-1:0]        out_hazard;
    logic                     in_issue_en;
    logic [AW-1:0]            in_issue_addr;
    logic [DEPTH-1:0]         out_busy;

    modport master (
        output in_wen, in_waddr, in_wdata, in_ren, in_raddr, in_issue_en, in_issue_addr,
        input  out_rdata, out_rvalid, out_hazard, out_busy
    );

    modport slave (
        input  in_wen, in_waddr, in_wdata, in_ren, in_raddr, in_issue_en, in_issue_addr,
        output out_rdata, out_rvalid, out_hazard, out_busy
    );

endinterface

// File: rtl/switch_mcu_regfile_mp_scoreboard.sv
// Per-register busy tracking: issue marks a destination busy, writeback clears it.
module switch_mcu_rf_scoreboard
    import switch_mcu_pkg::*;
#(
    parameter int DEPTH    = SWM_RF_DEPTH,
    parameter int ZERO_REG = 1,
    localparam int AW      = swm_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [DEPTH-1:0] busy
);

    logic [DEPTH-1:0] busy_next;

    // Set is applied after clear so a same-cycle issue (the new producer) wins.
    always_comb begin
        busy_next = busy;
        if (clr_en) busy_next[clr_addr] = 1'b0;
        if (set_en) busy_next[set_addr] = 1'b1;
        if (ZERO_REG != 0) busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

endmodule

// File: rtl/switch_mcu_regfile_mp.sv
// Multi-port register file with optional write bypass, hardwired zero register
// and busy scoreboard; all read results are registered.
module switch_mcu_regfile_mp
    import switch_mcu_pkg::*;
#(
    parameter int DATA_W   = SWM_DATA_W,
    parameter int DEPTH    = SWM_RF_DEPTH,
    parameter int NUM_RD   = SWM_RF_NUM_RD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic in_clk,
    input logic in_rst,
    switch_mcu_regfile_mp_if.slave rf
);
    localparam int AW = swm_aw(DEPTH);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_drop;
    logic              wr_eff;

    assign wr_drop = (ZERO_REG != 0) && (rf.in_waddr == '0);
    assign wr_eff  = rf.in_wen && !wr_drop;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_eff) begin
            regs[rf.in_waddr] <= rf.in_wdata;
        end
    end

    switch_mcu_rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (in_clk),
        .rst      (in_rst),
        .set_en   (rf.in_issue_en),
        .set_addr (rf.in_issue_addr),
        .clr_en   (rf.in_wen),
        .clr_addr (rf.in_waddr),
        .busy     (busy)
    );

    assign rf.out_busy = busy;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     ra;
        logic              hit;
        logic [DATA_W-1:0] rd_next;
        logic [DATA_W-1:0] rdata_q;
        logic              rvalid_q;
        logic              hazard_q;

        assign ra  = rf.in_raddr[k*AW +: AW];
        // A dropped write (to the zero register) never forwards.
        assign hit = (BYPASS != 0) && wr_eff && (rf.in_waddr == ra);

        always_comb begin
            rd_next = regs[ra];
            if ((ZERO_REG != 0) && (ra == '0)) rd_next = '0;
            else if (hit)                      rd_next = rf.in_wdata;
        end

        always_ff @(posedge in_clk) begin
            if (in_rst || !rf.in_ren[k]) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
                hazard_q <= 1'b0;
            end else begin
                rdata_q  <= rd_next;
                rvalid_q <= 1'b1;
                hazard_q <= busy[ra] && !hit;
            end
        end

        assign rf.out_rdata[k*DATA_W +: DATA_W] = rdata_q;
        assign rf.out_rvalid[k]                 = rvalid_q;
        assign rf.out_hazard[k]                 = hazard_q;
    end

endmodule

// File: tb/tb_switch_mcu_regfile_mp.sv
// Directed bench: default-configuration vector table plus hand sequences,
// and a narrow 3-port instance with bypass and zero register disabled.
module tb_switch_mcu_regfile_mp;
    import switch_mcu_pkg::*;

    logic clk;
    logic rst0;
    logic rst1;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    switch_mcu_regfile_mp_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) rf0 ();
    switch_mcu_regfile_mp_if #(.DATA_W(16), .DEPTH(16), .NUM_RD(3)) rf1 ();

    switch_mcu_regfile_mp #(
        .DATA_W(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)
    ) dut0 (
        .in_clk (clk),
        .in_rst (rst0),
        .rf     (rf0)
    );

    switch_mcu_regfile_mp #(
        .DATA_W(16), .DEPTH(16), .NUM_RD(3), .BYPASS(0), .ZERO_REG(0)
    ) dut1 (
        .in_clk (clk),
        .in_rst (rst1),
        .rf     (rf1)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  ren;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        issue;
        logic [4:0]  iaddr;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rv;
        logic [1:0]  e_hz;
        logic [31:0] e_busy;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input string n, input logic r, input logic we, input logic [4:0] wa,
        input logic [31:0] wd, input logic [1:0] re, input logic [4:0] a0,
        input logic [4:0] a1, input logic is, input logic [4:0] ia,
        input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] rv,
        input logic [1:0] hz, input logic [31:0] bz);
        vec_t v;
        v.name = n; v.rst = r; v.wen = we; v.waddr = wa; v.wdata = wd;
        v.ren = re; v.ra0 = a0; v.ra1 = a1; v.issue = is; v.iaddr = ia;
        v.e_rd0 = d0; v.e_rd1 = d1; v.e_rv = rv; v.e_hz = hz; v.e_busy = bz;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step0(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [1:0] re, input logic [9:0] ra, input logic is, input logic [4:0] ia);
        rst0 = r;
        rf0.in_wen = we; rf0.in_waddr = wa; rf0.in_wdata = wd;
        rf0.in_ren = re; rf0.in_raddr = ra;
        rf0.in_issue_en = is; rf0.in_issue_addr = ia;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic r, input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [2:0] re, input logic [11:0] ra, input logic is, input logic [3:0] ia);
        rst1 = r;
        rf1.in_wen = we; rf1.in_waddr = wa; rf1.in_wdata = wd;
        rf1.in_ren = re; rf1.in_raddr = ra;
        rf1.in_issue_en = is; rf1.in_issue_addr = ia;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        rf0.in_wen = 0; rf0.in_waddr = '0; rf0.in_wdata = '0; rf0.in_ren = '0;
        rf0.in_raddr = '0; rf0.in_issue_en = 0; rf0.in_issue_addr = '0;
        rf1.in_wen = 0; rf1.in_waddr = '0; rf1.in_wdata = '0; rf1.in_ren = '0;
        rf1.in_raddr = '0; rf1.in_issue_en = 0; rf1.in_issue_addr = '0;

        //              name          rst we wa     wdata         ren   a0     a1     is ia     rd0           rd1           rv     hz     busy
        vecs[0]  = mk("reset",        1, 0, 5'd0, 32'h0,        2'b00, 5'd0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0);
        vecs[1]  = mk("wr_r5",        0, 1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0);
        vecs[2]  = mk("rd_r5_p1",     0, 0, 5'd0, 32'h0,        2'b10, 5'd0, 5'd5, 0, 5'd0, 32'h0,        32'hDEADBEEF, 2'b10, 2'b00, 32'h0);
        vecs[3]  = mk("rd_r5_r0",     0, 1, 5'd7, 32'h11,       2'b11, 5'd5, 5'd0, 0, 5'd0, 32'hDEADBEEF, 32'h0,        2'b11, 2'b00, 32'h0);
        vecs[4]  = mk("bypass_r7",    0, 1, 5'd7, 32'h22,       2'b11, 5'd7, 5'd7, 0, 5'd0, 32'h22,       32'h22,       2'b11, 2'b00, 32'h0);
        vecs[5]  = mk("rd_r7",        0, 0, 5'd0, 32'h0,        2'b11, 5'd7, 5'd7, 0, 5'd0, 32'h22,       32'h22,       2'b11, 2'b00, 32'h0);
        vecs[6]  = mk("zero_wr_iss",  0, 1, 5'd0, 32'hFFFFFFFF, 2'b01, 5'd0, 5'd0, 1, 5'd0, 32'h0,        32'h0,        2'b01, 2'b00, 32'h0);
        vecs[7]  = mk("zero_rd",      0, 0, 5'd0, 32'h0,        2'b01, 5'd0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        2'b01, 2'b00, 32'h0);
        vecs[8]  = mk("issue_r3",     0, 0, 5'd0, 32'h0,        2'b00, 5'd0, 5'd0, 1, 5'd3, 32'h0,        32'h0,        2'b00, 2'b00, 32'h8);
        vecs[9]  = mk("hazard_r3",    0, 0, 5'd0, 32'h0,        2'b01, 5'd3, 5'd0, 0, 5'd0, 32'h0,        32'h0,        2'b01, 2'b01, 32'h8);
        vecs[10] = mk("wb_bypass_r3", 0, 1, 5'd3, 32'h33,       2'b10, 5'd0, 5'd3, 0, 5'd0, 32'h0,        32'h33,       2'b10, 2'b00, 32'h0);
        vecs[11] = mk("iss_wr_same",  0, 1, 5'd3, 32'h44,       2'b11, 5'd3, 5'd3, 1, 5'd3, 32'h44,       32'h44,       2'b11, 2'b00, 32'h8);
        vecs[12] = mk("busy_kept",    0, 0, 5'd0, 32'h0,        2'b11, 5'd3, 5'd3, 0, 5'd0, 32'h44,       32'h44,       2'b11, 2'b11, 32'h8);
        vecs[13] = mk("reissue_r3",   0, 0, 5'd0, 32'h0,        2'b00, 5'd0, 5'd0, 1, 5'd3, 32'h0,        32'h0,        2'b00, 2'b00, 32'h8);
        vecs[14] = mk("clear_r3",     0, 1, 5'd3, 32'h55,       2'b00, 5'd0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0);
        vecs[15] = mk("rst_priority", 1, 1, 5'd9, 32'h99,       2'b11, 5'd9, 5'd5, 1, 5'd9, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0);
        vecs[16] = mk("post_rst_rd",  0, 0, 5'd0, 32'h0,        2'b11, 5'd9, 5'd5, 0, 5'd0, 32'h0,        32'h0,        2'b11, 2'b00, 32'h0);

        // Reset after random contents and outstanding issues wipes everything.
        step0(1, 0, 5'd0, 32'h0, 2'b00, 10'd0, 0, 5'd0);
        for (int i = 1; i < 32; i++)
            step0(0, 1, 5'(i), $urandom, 2'b00, 10'd0, 1, 5'($urandom_range(1, 31)));
        check("preload_busy_nonzero", 64'(rf0.out_busy != 0), 64'd1);
        step0(1, 0, 5'd0, 32'h0, 2'b00, 10'd0, 0, 5'd0);
        check("rst_busy", 64'(rf0.out_busy), 64'h0);
        for (int i = 0; i < 16; i++) begin
            step0(0, 0, 5'd0, 32'h0, 2'b11, {5'(i + 16), 5'(i)}, 0, 5'd0);
            check($sformatf("rst_rdata_%0d", i), 64'(rf0.out_rdata), 64'h0);
            check($sformatf("rst_rvalid_%0d", i), 64'(rf0.out_rvalid), 64'h3);
            check($sformatf("rst_hazard_%0d", i), 64'(rf0.out_hazard), 64'h0);
        end

        for (int i = 0; i < NV; i++) begin
            step0(vecs[i].rst, vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].ren,
                  {vecs[i].ra1, vecs[i].ra0}, vecs[i].issue, vecs[i].iaddr);
            check({vecs[i].name, "_rdata"},  64'(rf0.out_rdata),  64'({vecs[i].e_rd1, vecs[i].e_rd0}));
            check({vecs[i].name, "_rvalid"}, 64'(rf0.out_rvalid), 64'(vecs[i].e_rv));
            check({vecs[i].name, "_hazard"}, 64'(rf0.out_hazard), 64'(vecs[i].e_hz));
            check({vecs[i].name, "_busy"},   64'(rf0.out_busy),   64'(vecs[i].e_busy));
        end
        rst0 = 1'b0;

        // Narrow instance: no bypass, no zero register, three ports.
        step1(1, 0, 4'd0, 16'h0, 3'b000, 12'h0, 0, 4'd0);
        check("p_rst_rdata", 64'(rf1.out_rdata), 64'h0);
        check("p_rst_busy", 64'(rf1.out_busy), 64'h0);
        step1(0, 1, 4'd1, 16'h1111, 3'b000, 12'h0, 0, 4'd0);
        step1(0, 1, 4'd2, 16'h2222, 3'b000, 12'h0, 0, 4'd0);
        step1(0, 1, 4'd3, 16'h3333, 3'b000, 12'h0, 0, 4'd0);
        step1(0, 0, 4'd0, 16'h0, 3'b111, {4'd3, 4'd2, 4'd1}, 0, 4'd0);
        check("p_three_ports_rdata", 64'(rf1.out_rdata), 64'h3333_2222_1111);
        check("p_three_ports_rvalid", 64'(rf1.out_rvalid), 64'h7);
        step1(0, 1, 4'd7, 16'h0011, 3'b000, 12'h0, 0, 4'd0);
        step1(0, 1, 4'd7, 16'h0022, 3'b111, {4'd7, 4'd7, 4'd7}, 0, 4'd0);
        check("p_nobypass_rdata", 64'(rf1.out_rdata), 64'h0011_0011_0011);
        check("p_nobypass_hazard", 64'(rf1.out_hazard), 64'h0);
        step1(0, 0, 4'd0, 16'h0, 3'b000, 12'h0, 1, 4'd7);
        check("p_issue_busy", 64'(rf1.out_busy), 64'h0080);
        step1(0, 1, 4'd7, 16'h0033, 3'b001, {4'd0, 4'd0, 4'd7}, 0, 4'd0);
        check("p_wb_old_rdata", 64'(rf1.out_rdata), 64'h0000_0000_0022);
        check("p_wb_hazard", 64'(rf1.out_hazard), 64'h1);
        check("p_wb_busy", 64'(rf1.out_busy), 64'h0);
        step1(0, 1, 4'd0, 16'hFFFF, 3'b000, 12'h0, 1, 4'd0);
        check("p_r0_busy", 64'(rf1.out_busy), 64'h0001);
        step1(0, 0, 4'd0, 16'h0, 3'b001, 12'h0, 0, 4'd0);
        check("p_r0_rdata", 64'(rf1.out_rdata), 64'h0000_0000_FFFF);
        check("p_r0_hazard", 64'(rf1.out_hazard), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_mcu_regfile_mp.md
# switch_mcu_regfile_mp

Parametrised multi-port register file for the switch MCU core, replacing the fixed 32x32, two-read-port register file. It adds configurable width, depth and read-port count, optional write-to-read bypass, a hardwired-zero register option and a per-register busy scoreboard. It sits between decode (read and issue) and writeback (write and busy clear).

## Interface
Parameters:
- DATA_W, 32: register width in bits.
- DEPTH, 32: number of registers; power of two, at least 2. AW = $clog2(DEPTH).
- NUM_RD, 2: number of read ports, 1 to 4.
- BYPASS, 1: 1 forwards same-cycle write data to a matching read; 0 returns the old contents.
- ZERO_REG, 1: 1 makes register 0 read as 0, ignore writes and never become busy.

Ports:
- in_clk  input  1  the single clock; all state updates on its rising edge.
- in_rst  input  1  reset, synchronous and active-high.
- in_wen  input  1  write enable (writeback).
- in_waddr  input  AW  write address.
- in_wdata  input  DATA_W  write data.
- in_ren  input  NUM_RD  per-port read enable.
- in_raddr  input  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- out_rdata  output  NUM_RD*DATA_W  packed registered read data.
- out_rvalid  output  NUM_RD  registered; high for one cycle per accepted read.
- out_hazard  output  NUM_RD  registered; the read hit a busy register and received no bypass.
- in_issue_en  input  1  marks the destination register of an issued instruction as busy.
- in_issue_addr  input  AW  destination register being issued.
- out_busy  output  DEPTH  current busy vector, driven directly from state.

## Operation
- Reset, applied at the edge where in_rst=1:
  - every register, out_rdata, out_rvalid, out_hazard and out_busy clears to 0;
  - reset takes priority over every other input in that cycle, including a concurrent write or issue.
- Write: when in_wen=1, regs[in_waddr] <= in_wdata at the edge. With ZERO_REG=1 and in_waddr=0, the write is dropped.
- Read, port k, registered at the edge:
  - in_ren[k]=0: out_rdata_k <= 0, out_rvalid[k] <= 0, out_hazard[k] <= 0.
  - in_ren[k]=1:
    - out_rvalid[k] <= 1;
    - out_rdata_k <= the bypass value if the bypass applies, else regs[raddr_k];
    - with ZERO_REG=1 and raddr_k=0, out_rdata_k <= 0.
  - The bypass applies when BYPASS=1, in_wen=1, in_waddr==raddr_k and the write is not dropped; the bypass value is in_wdata.
- Hazard: out_hazard[k] <= in_ren[k] && busy[raddr_k] && !bypass_hit_k.
  - A read satisfied by the bypass is never a hazard.
  - With BYPASS=0, a read of a register being written back in the same cycle is still flagged and returns the old data.
- Scoreboard:
  - in_issue_en=1 sets busy[in_issue_addr];
  - in_wen=1 clears busy[in_waddr];
  - issue and write to the same address in the same cycle leave it set, because the new producer wins;
  - with ZERO_REG=1, busy[0] stays 0;
  - issuing to a register that is already busy keeps it set; there is no count of outstanding writes.
- Ports are independent: several ports may read the same address in the same cycle, and each returns identical data.

## Timing
- Read latency is 1 cycle: the address is presented at edge N and the data and flags are valid after edge N, held until edge N+1.
- A write at edge N is visible to a non-bypassed read presented at edge N+1.
- The busy set/clear from edge N is seen in out_busy after edge N and affects out_hazard for reads presented at edge N+1.
- Reset mid-operation: at the next edge all outputs are 0; reads in flight are lost and no rvalid is produced for them.
- There is no backpressure; every enabled read completes.

## Structure
- A shared package switch_mcu_pkg holds:
  - default parameters SWM_DATA_W=32, SWM_RF_DEPTH=32, SWM_RF_NUM_RD=2;
  - the helper function for AW.
- One sub-module, switch_mcu_rf_scoreboard, holds the busy vector and its set/clear/reset logic. It takes the parameters DEPTH and ZERO_REG.
- The read ports are built with a generate loop over NUM_RD; the bypass compare is per port.

## Test plan
- Reset: load random data, then pulse in_rst=1 for one cycle → all reads return 0 with rvalid=1, and out_busy=0.
- Write then read: write 0xDEADBEEF to r5 at edge N, read r5 on port 1 at edge N+1 → out_rdata_1=0xDEADBEEF and rvalid[1]=1 after edge N+1; with ren=0 the port returns 0 with rvalid=0.
- Bypass: r7=0x11, then write 0x22 to r7 and read r7 on both ports at the same edge → both ports return 0x22 with hazard=0; with BYPASS=0 both return 0x11.
- Zero register: write 0xFFFFFFFF to r0 and issue r0 → a read of r0 returns 0 and out_busy[0] stays 0; with ZERO_REG=0 the read returns 0xFFFFFFFF.
- Scoreboard:
  - issue r3, then read r3 → hazard=1;
  - writeback r3 with a same-cycle read → bypassed data, hazard=0;
  - issue and write r3 in the same cycle → busy[3] stays 1.
- Parameter sweep: DEPTH=16, NUM_RD=3, DATA_W=16 → all scenarios above pass, and three ports reading distinct addresses each return their own register.
